// File: rtl/encrypt_mul_scheduler.sv
// Time-multiplexes one shared polynomial multiplier across the six Baby Kyber
// encryption products, reducing mod Q and emitting paired sums (u0, u1, v-partial).
// Optional watchdog on the multiplier handshake: define ENCRYPT_MUL_WATCHDOG_EN.
module encrypt_mul_scheduler #(
  parameter int Q           = 17,
  parameter int N_COEF      = 4,
  parameter int MUL_TIMEOUT = 64,
  localparam int W          = $clog2(Q)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  mul_start,
  output logic [2:0]            mul_sel,
  input  logic                  mul_done,
  input  logic [32*N_COEF-1:0]  mul_result,
  output logic                  res_wr,
  output logic [1:0]            res_idx,
  output logic [W*N_COEF-1:0]   res_data,
  output logic                  err
);

  // Handshake: mul_start is a one-cycle launch with mul_sel valid; the
  // multiplier answers with a one-cycle mul_done (with mul_result) at least one
  // cycle later. mul_done is only honoured while waiting; res_wr is a one-cycle
  // strobe qualifying res_idx/res_data, with no back-pressure.

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_ACCUM = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [W:0] QW = Q[W:0];

  if (MUL_TIMEOUT < 2) begin : g_timeout_range_check
    $error("MUL_TIMEOUT must be at least 2");
  end

  state_t                 state_q, state_d;
  logic [2:0]             idx_q, idx_d;
  logic [W*N_COEF-1:0]    acc_q, acc_d;
  logic [32*N_COEF-1:0]   prod_q, prod_d;
  logic                   res_wr_q, res_wr_d;
  logic [1:0]             res_idx_q, res_idx_d;
  logic [W*N_COEF-1:0]    res_data_q, res_data_d;
  logic [W*N_COEF-1:0]    red_all, sum_all;

  // Signed truncating remainder, folded into [0, Q-1].
  function automatic logic [W-1:0] red_mod(input logic [31:0] x);
    logic signed [31:0] r;
    r = $signed(x) % Q;
    if (r < 0) r = r + Q;
    return r[W-1:0];
  endfunction

  for (genvar g = 0; g < N_COEF; g++) begin : g_coef
    logic [W:0] s;
    assign red_all[W*g +: W] = red_mod(prod_q[32*g +: 32]);
    assign s = {1'b0, acc_q[W*g +: W]} + {1'b0, red_all[W*g +: W]};
    assign sum_all[W*g +: W] = (s >= QW) ? W'(s - QW) : s[W-1:0];
  end

`ifdef ENCRYPT_MUL_WATCHDOG_EN
  localparam int WD_W = $clog2(MUL_TIMEOUT + 1);
  logic [WD_W-1:0] wd_q, wd_d;
  logic            err_q, err_d;
`endif

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    acc_d      = acc_q;
    prod_d     = prod_q;
    res_wr_d   = 1'b0;
    res_idx_d  = res_idx_q;
    res_data_d = res_data_q;
    mul_start  = 1'b0;
    done       = 1'b0;
`ifdef ENCRYPT_MUL_WATCHDOG_EN
    wd_d       = wd_q;
    err_d      = err_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          idx_d   = 3'd0;
          state_d = S_ISSUE;
`ifdef ENCRYPT_MUL_WATCHDOG_EN
          wd_d    = '0;
`endif
        end
      end
      S_ISSUE: begin
        mul_start = 1'b1;
        state_d   = S_WAIT;
`ifdef ENCRYPT_MUL_WATCHDOG_EN
        wd_d      = '0;
`endif
      end
      S_WAIT: begin
        if (mul_done) begin
          prod_d  = mul_result;
          state_d = S_ACCUM;
        end
`ifdef ENCRYPT_MUL_WATCHDOG_EN
        else if (wd_q == WD_W'(MUL_TIMEOUT - 1)) begin
          // Timeout abandons the run: no further writes, just signal done.
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          wd_d = wd_q + 1'b1;
        end
`endif
      end
      S_ACCUM: begin
        if (!idx_q[0]) begin
          acc_d = red_all;
        end else begin
          res_wr_d   = 1'b1;
          res_idx_d  = idx_q[2:1];
          res_data_d = sum_all;
        end
        if (idx_q == 3'd5) begin
          state_d = S_DONE;
        end else begin
          idx_d   = idx_q + 3'd1;
          state_d = S_ISSUE;
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      acc_q      <= '0;
      prod_q     <= '0;
      res_wr_q   <= 1'b0;
      res_idx_q  <= '0;
      res_data_q <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      acc_q      <= acc_d;
      prod_q     <= prod_d;
      res_wr_q   <= res_wr_d;
      res_idx_q  <= res_idx_d;
      res_data_q <= res_data_d;
    end
  end

`ifdef ENCRYPT_MUL_WATCHDOG_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_q  <= '0;
      err_q <= 1'b0;
    end else begin
      wd_q  <= wd_d;
      err_q <= err_d;
    end
  end
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign busy     = (state_q != S_IDLE);
  assign mul_sel  = idx_q;
  assign res_wr   = res_wr_q;
  assign res_idx  = res_idx_q;
  assign res_data = res_data_q;

endmodule

// File: tb/tb_encrypt_mul_scheduler.sv
// Scoreboard bench for encrypt_mul_scheduler: a latency-configurable multiplier
// model answers mul_start, expected writes are queued, a monitor checks them.
module tb_encrypt_mul_scheduler;
  localparam int NC = 4;
  localparam int W  = 5;

  logic              clk = 1'b0;
  logic              rst_n, start, mul_done;
  logic [32*NC-1:0]  mul_result;
  logic              busy, done, mul_start, res_wr, err;
  logic [2:0]        mul_sel;
  logic [1:0]        res_idx;
  logic [W*NC-1:0]   res_data;

  encrypt_mul_scheduler dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .mul_start(mul_start), .mul_sel(mul_sel), .mul_done(mul_done),
    .mul_result(mul_result), .res_wr(res_wr), .res_idx(res_idx),
    .res_data(res_data), .err(err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  logic [W*NC+1:0]  exp_q[$];
  logic [W*NC+1:0]  exp_e;
  logic [32*NC-1:0] prod_tbl[6];
  int mul_lat = 1;
  bit spur = 1'b0;
  bit no_resp = 1'b0;
  int mul_start_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  function automatic logic [32*NC-1:0] p4(input int c0, input int c1, input int c2, input int c3);
    return {c3, c2, c1, c0};
  endfunction

  function automatic logic [W*NC-1:0] d4(input logic [4:0] c0, input logic [4:0] c1,
                                         input logic [4:0] c2, input logic [4:0] c3);
    return {c3, c2, c1, c0};
  endfunction

  task automatic push(input logic [1:0] idx, input logic [W*NC-1:0] data);
    exp_q.push_back({idx, data});
  endtask

  task automatic fill_ones();
    for (int i = 0; i < 6; i++) prod_tbl[i] = p4(1, 1, 1, 1);
  endtask

  task automatic push_twos();
    for (int i = 0; i < 3; i++) push(i[1:0], d4(2, 2, 2, 2));
  endtask

  // Monitor: pops the scoreboard on every write, checks operand order.
  always @(negedge clk) begin
    if (rst_n && res_wr) begin
      if (exp_q.size() == 0) begin
        check("res_unexpected", {30'd0, res_idx}, 32'hFFFF_FFFF);
      end else begin
        exp_e = exp_q.pop_front();
        check("res_idx", {30'd0, res_idx}, {30'd0, exp_e[W*NC+1:W*NC]});
        check("res_data", {12'd0, res_data}, {12'd0, exp_e[W*NC-1:0]});
      end
    end
    if (rst_n && mul_start) begin
      check("mul_sel_order", {29'd0, mul_sel}, mul_start_cnt);
      mul_start_cnt++;
    end
  end

  // Multiplier model: mul_done arrives mul_lat cycles after mul_start.
  initial begin : mul_model
    logic [2:0] sel;
    forever begin
      @(negedge clk);
      if (rst_n && mul_start) begin
        sel = mul_sel;
        if (spur) begin
          mul_done   = 1'b1;
          mul_result = {NC{32'd7}};
        end
        if (!no_resp) begin
          @(negedge clk);
          mul_done = 1'b0;
          repeat (mul_lat - 1) @(negedge clk);
          if (busy) check("mul_sel_stable", {29'd0, mul_sel}, {29'd0, sel});
          mul_done   = 1'b1;
          mul_result = prod_tbl[sel];
          @(negedge clk);
          mul_done = 1'b0;
        end else begin
          @(negedge clk);
          mul_done = 1'b0;
        end
      end
    end
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, {31'd0, busy}, 0);
    check({tag, "_done"}, {31'd0, done}, 0);
    check({tag, "_mul_start"}, {31'd0, mul_start}, 0);
    check({tag, "_res_wr"}, {31'd0, res_wr}, 0);
    check({tag, "_mul_sel"}, {29'd0, mul_sel}, 0);
    check({tag, "_res_idx"}, {30'd0, res_idx}, 0);
    check({tag, "_res_data"}, {12'd0, res_data}, 0);
    check({tag, "_err"}, {31'd0, err}, 0);
  endtask

  // Runs one sequence; cycle 0 is the edge that samples start.
  task automatic run_seq(input int lat, input int exp_done, input bit hold);
    int cyc;
    bit seen;
    mul_lat = lat;
    mul_start_cnt = 0;
    @(negedge clk);
    start = 1'b1;
    cyc = 0;
    seen = 1'b0;
    while (!seen && cyc < exp_done + 50) begin
      @(negedge clk);
      cyc++;
      if (!hold || done) start = 1'b0;
      if (cyc == 1) check("busy_after_start", {31'd0, busy}, 1);
      if (done) seen = 1'b1;
    end
    start = 1'b0;
    check("done_seen", {31'd0, seen}, 1);
    check("done_cycle", cyc, exp_done);
    @(negedge clk);
    check("busy_after_done", {31'd0, busy}, 0);
    check("done_one_cycle", {31'd0, done}, 0);
    check("mul_start_count", mul_start_cnt, 6);
    check("exp_q_drained", exp_q.size(), 0);
    check("err_clear", {31'd0, err}, 0);
  endtask

  initial begin : global_timeout
    #500000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    mul_done = 1'b0;
    mul_result = '0;
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Basic: all-ones products give 2 in every coefficient.
    fill_ones();
    push_twos();
    run_seq(1, 19, 1'b0);

    // Negative reduction in the v-partial pair.
    fill_ones();
    prod_tbl[4] = p4(-1, -18, -35, 0);
    prod_tbl[5] = p4(0, 0, 0, 0);
    push(2'd0, d4(2, 2, 2, 2));
    push(2'd1, d4(2, 2, 2, 2));
    push(2'd2, d4(16, 16, 16, 0));
    run_seq(1, 19, 1'b0);

    // Wrap-around: 16,33,100,-100 reduce to 16,16,15,2; doubled mod 17.
    fill_ones();
    prod_tbl[0] = p4(16, 33, 100, -100);
    prod_tbl[1] = p4(16, 33, 100, -100);
    push(2'd0, d4(15, 15, 13, 4));
    push(2'd1, d4(2, 2, 2, 2));
    push(2'd2, d4(2, 2, 2, 2));
    run_seq(1, 19, 1'b0);

    // Start held high plus a spurious mul_done in ISSUE; then a fresh run.
    fill_ones();
    spur = 1'b1;
    push_twos();
    run_seq(1, 19, 1'b1);
    spur = 1'b0;
    push_twos();
    run_seq(1, 19, 1'b0);

    // Long multiplier latency with an asymmetric u1 pair.
    fill_ones();
    prod_tbl[2] = p4(20, 0, 0, 0);
    prod_tbl[3] = p4(0, 0, 0, 5);
    push(2'd0, d4(2, 2, 2, 2));
    push(2'd1, d4(3, 0, 0, 5));
    push(2'd2, d4(2, 2, 2, 2));
    run_seq(7, 55, 1'b0);

    // Reset while waiting on product 3.
    fill_ones();
    push_twos();
    mul_lat = 3;
    mul_start_cnt = 0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 100 && mul_start_cnt < 4; i++) begin
      @(negedge clk);
      #1;
    end
    check("reach_product3", mul_start_cnt, 4);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_all_zero("midrun_reset");
    check("pending_writes", exp_q.size(), 2);
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("no_issue_after_reset", mul_start_cnt, 4);
    check("idle_after_reset", {31'd0, busy}, 0);

`ifdef ENCRYPT_MUL_WATCHDOG_EN
    begin : watchdog_test
      int cyc;
      bit seen;
      no_resp = 1'b1;
      mul_start_cnt = 0;
      @(negedge clk);
      start = 1'b1;
      cyc = 0;
      seen = 1'b0;
      while (!seen && cyc < 200) begin
        @(negedge clk);
        cyc++;
        start = 1'b0;
        if (done) seen = 1'b1;
      end
      check("wd_done_seen", {31'd0, seen}, 1);
      check("wd_done_cycle", cyc, 66);
      check("wd_err_set", {31'd0, err}, 1);
      @(negedge clk);
      check("wd_err_sticky", {31'd0, err}, 1);
      check("wd_idle", {31'd0, busy}, 0);
      check("wd_single_issue", mul_start_cnt, 1);
      no_resp = 1'b0;
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
